// File: rtl/debug_ctrl_pkg.sv
// Shared types and default constants for the debug-state button controller.
package debug_ctrl_pkg;

    // Defaults sized for a 50 MHz board clock: 5 ms debounce, 1 s long press.
    localparam int unsigned DBG_DEBOUNCE_DEF   = 250000;
    localparam int unsigned DBG_LONG_DEF       = 50000000;
    localparam int unsigned DBG_NUM_STATES_DEF = 4;

    // Press-classification FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_LONG_HELD,
        ST_RELEASE_WAIT
    } dbg_fsm_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit board input.
// Asynchronous active-high reset clears both stages to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/debug_mode_ctrl.sv
// Debug-state controller: synchronizes and debounces a push-button,
// classifies each press as short or long and sequences a small debug
// state register. A short press advances the state (with wrap); a long
// press returns to state 0.
// Build option DEBUG_LONG_REVERSE_EN: a long press steps the state
// backward (with wrap) and always pulses state_changed.
module debug_mode_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DBG_DEBOUNCE_DEF,
    parameter int unsigned LONG_CYCLES     = DBG_LONG_DEF,
    parameter int unsigned NUM_STATES      = DBG_NUM_STATES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_raw,
    output logic [$clog2(NUM_STATES)-1:0] d_state,
    output logic                          state_changed,
    output logic                          btn_level
);

    localparam int unsigned SW = $clog2(NUM_STATES);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(LONG_CYCLES);

    // Terminal counts; counters stop here rather than wrapping.
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(NUM_STATES - 1);

    logic          btn_s;

    dbg_fsm_t      fsm_q,       fsm_d;
    logic [DW-1:0] dcnt_q,      dcnt_d;
    logic [HW-1:0] hcnt_q,      hcnt_d;
    logic          long_seen_q, long_seen_d;
    logic [SW-1:0] d_state_q,   d_state_d;
    logic          changed_q,   changed_d;
    logic          level_q,     level_d;

    sync_2ff u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_raw),
        .q_o (btn_s)
    );

    // Next-state logic: debounce, hold timing and the short/long actions.
    always_comb begin
        fsm_d       = fsm_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        long_seen_d = long_seen_q;
        d_state_d   = d_state_q;
        changed_d   = 1'b0;
        level_d     = level_q;

        unique case (fsm_q)
            ST_IDLE: begin
                if (btn_s) begin
                    fsm_d  = ST_PRESS_WAIT;
                    dcnt_d = '0;
                end
            end

            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    fsm_d = ST_IDLE;
                end else if (dcnt_q == D_LAST) begin
                    fsm_d   = ST_HELD;
                    level_d = 1'b1;
                    hcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            ST_HELD: begin
                if (!btn_s) begin
                    fsm_d       = ST_RELEASE_WAIT;
                    dcnt_d      = '0;
                    long_seen_d = 1'b0;
                end else if (hcnt_q == H_LAST) begin
                    fsm_d = ST_LONG_HELD;
`ifdef DEBUG_LONG_REVERSE_EN
                    d_state_d = (d_state_q == '0) ? S_LAST : d_state_q - 1'b1;
                    changed_d = 1'b1;
`else
                    d_state_d = '0;
                    changed_d = (d_state_q != '0);
`endif
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end

            ST_LONG_HELD: begin
                if (!btn_s) begin
                    fsm_d       = ST_RELEASE_WAIT;
                    dcnt_d      = '0;
                    long_seen_d = 1'b1;
                end
            end

            ST_RELEASE_WAIT: begin
                // A release bounce resumes the held state with hcnt intact,
                // so bouncing neither restarts nor advances long-press timing.
                if (btn_s) begin
                    fsm_d = long_seen_q ? ST_LONG_HELD : ST_HELD;
                end else if (dcnt_q == D_LAST) begin
                    fsm_d   = ST_IDLE;
                    level_d = 1'b0;
                    if (!long_seen_q) begin
                        d_state_d = (d_state_q == S_LAST) ? '0 : d_state_q + 1'b1;
                        changed_d = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end

            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            long_seen_q <= 1'b0;
            d_state_q   <= '0;
            changed_q   <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            long_seen_q <= long_seen_d;
            d_state_q   <= d_state_d;
            changed_q   <= changed_d;
            level_q     <= level_d;
        end
    end

    assign d_state       = d_state_q;
    assign state_changed = changed_q;
    assign btn_level     = level_q;

endmodule
